// File: rtl/control_unit.sv
// Hardwired Moore control unit: step counter plus opcode decode driving every datapath strobe.
// Optional CU_MULDIV_EN macro enables the mul/div sequence; without it mul/div behave as nop.
module control_unit (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] IR,
  output logic        dp_clear,
  output logic        run,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIout,
  output logic        LOout,
  output logic        Inportout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        Yin,
  output logic        Zin,
  output logic        MDRin,
  output logic        HIin,
  output logic        LOin,
  output logic        Rin,
  output logic        OutPort,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        read,
  output logic        write,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        IncPC
);

`ifdef CU_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001, OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111, OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001, OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_HALT = 5'b11011;

  // T0..T7 encode their step number directly so the step index is state[2:0].
  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_RESET = 4'd8, S_HALT = 4'd9
  } state_t;

  state_t      state, state_next;
  logic [4:0]  opcode;
  logic [2:0]  step, last_step;
  logic        is_alu, is_imm, is_unary, is_muldiv, is_mem, is_single, is_halt;
  logic        op_en;
  logic        ir_fields_unused;

  assign opcode           = IR[31:27];
  assign ir_fields_unused = ^IR[26:0];
  assign step             = state[2:0];

  assign is_alu    = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHL};
  assign is_imm    = opcode inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign is_unary  = opcode inside {OP_NEG, OP_NOT};
  assign is_muldiv = MULDIV_EN && (opcode inside {OP_MUL, OP_DIV});
  assign is_mem    = opcode inside {OP_LD, OP_LDI, OP_ST};
  assign is_single = opcode inside {OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO};
  assign is_halt   = (opcode == OP_HALT);

  always_comb begin
    last_step = 3'd2;
    if (is_single)                       last_step = 3'd3;
    else if (is_unary)                   last_step = 3'd4;
    else if (is_alu || is_imm)           last_step = 3'd5;
    else if (opcode == OP_LDI)           last_step = 3'd5;
    else if (is_muldiv || is_mem)        last_step = 3'd7;
  end

  always_ff @(posedge clk) begin
    if (clear) state <= S_RESET;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET: state_next = S_T0;
      S_HALT:  state_next = S_HALT;
      default: begin
        if (step == last_step) state_next = is_halt ? S_HALT : S_T0;
        else                   state_next = state_t'({1'b0, step + 3'd1});
      end
    endcase
  end

  always_comb begin
    dp_clear = 1'b0; run = 1'b0;
    PCout = 1'b0; MDRout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; Inportout = 1'b0; Cout = 1'b0; BAout = 1'b0; Rout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    MDRin = 1'b0; HIin = 1'b0; LOin = 1'b0; Rin = 1'b0; OutPort = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; read = 1'b0; write = 1'b0;
    AND = 1'b0; OR = 1'b0; ADD = 1'b0; SUB = 1'b0; MUL = 1'b0; DIV = 1'b0;
    SHR = 1'b0; SHL = 1'b0; ROR = 1'b0; ROL = 1'b0; NEG = 1'b0; NOT = 1'b0;
    IncPC = 1'b0;
    op_en = 1'b0;

    case (state)
      S_RESET: dp_clear = 1'b1;
      S_HALT:  ;
      S_T0: begin run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1; end
      S_T2: begin run = 1'b1; MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        run = 1'b1;
        if (is_alu || is_imm) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_unary)    begin Grb = 1'b1; Rout = 1'b1; op_en = 1'b1; Zin = 1'b1; end
        else if (is_muldiv)   begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_mem)      begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        else begin
          case (opcode)
            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_IN:   begin Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        run = 1'b1;
        if (is_alu)           begin Grc = 1'b1; Rout = 1'b1; op_en = 1'b1; Zin = 1'b1; end
        else if (is_imm)      begin Cout = 1'b1; op_en = 1'b1; Zin = 1'b1; end
        else if (is_unary)    begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_muldiv)   begin Grb = 1'b1; Rout = 1'b1; op_en = 1'b1; Zin = 1'b1; end
        else if (is_mem)      begin Cout = 1'b1; op_en = 1'b1; Zin = 1'b1; end
      end
      S_T5: begin
        run = 1'b1;
        if (is_alu || is_imm || opcode == OP_LDI) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_muldiv)   begin Zlowout = 1'b1; LOin = 1'b1; end
        else if (is_mem)      begin Zlowout = 1'b1; MARin = 1'b1; end
      end
      S_T6: begin
        run = 1'b1;
        if (is_muldiv)             begin Zhighout = 1'b1; HIin = 1'b1; end
        else if (opcode == OP_LD)  begin read = 1'b1; MDRin = 1'b1; end
        else if (opcode == OP_ST)  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      end
      S_T7: begin
        run = 1'b1;
        if (opcode == OP_LD)       begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (opcode == OP_ST)  write = 1'b1;
      end
      default: ;
    endcase

    // Address arithmetic for ld/ldi/st reuses the adder.
    if (op_en) begin
      case (opcode)
        OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST: ADD = 1'b1;
        OP_SUB:           SUB = 1'b1;
        OP_AND, OP_ANDI:  AND = 1'b1;
        OP_OR, OP_ORI:    OR  = 1'b1;
        OP_ROR:           ROR = 1'b1;
        OP_ROL:           ROL = 1'b1;
        OP_SHR:           SHR = 1'b1;
        OP_SHL:           SHL = 1'b1;
        OP_MUL:           MUL = MULDIV_EN;
        OP_DIV:           DIV = MULDIV_EN;
        OP_NEG:           NEG = 1'b1;
        OP_NOT:           NOT = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed and random instructions compared against
// a per-instruction micro-step table built from the instruction set description.
module tb_control_unit;

  logic        clk, clear;
  logic [31:0] IR;
  logic dp_clear, run, PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout, Rout;
  logic PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, Rin, OutPort, Gra, Grb, Grc, read, write;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;

  control_unit dut (
    .clk(clk), .clear(clear), .IR(IR), .dp_clear(dp_clear), .run(run),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout),
    .LOout(LOout), .Inportout(Inportout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .Yin(Yin), .Zin(Zin), .MDRin(MDRin),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .OutPort(OutPort), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .read(read), .write(write), .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL),
    .DIV(DIV), .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .IncPC(IncPC)
  );

`ifdef CU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  localparam int DPCLR = 39, RUN = 38, PCOUT = 37, MDROUT = 36, ZHOUT = 35, ZLOUT = 34;
  localparam int HIOUT = 33, LOOUT = 32, INPOUT = 31, COUT = 30, BAOUT = 29, ROUT = 28;
  localparam int PCIN = 27, IRIN = 26, MARIN = 25, YIN = 24, ZIN = 23, MDRIN = 22;
  localparam int HIIN = 21, LOIN = 20, RIN = 19, OUTP = 18, GRA = 17, GRB = 16, GRC = 15;
  localparam int RD = 14, WR = 13, O_AND = 12, O_OR = 11, O_ADD = 10, O_SUB = 9, O_MUL = 8;
  localparam int O_DIV = 7, O_SHR = 6, O_SHL = 5, O_ROR = 4, O_ROL = 3, O_NEG = 2, O_NOT = 1;
  localparam int INCPC = 0;

  logic [39:0] obs;
  assign obs = {dp_clear, run, PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout,
                BAout, Rout, PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, Rin, OutPort,
                Gra, Grb, Grc, read, write, AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL,
                NEG, NOT, IncPC};

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_seq [8];
  int          exp_len;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [39:0] b(input int i);
    return 40'(1) << i;
  endfunction

  // Micro-program for one instruction, listed step by step from the instruction description.
  task automatic build_expected(input logic [31:0] ir);
    logic [4:0] op;
    int a;
    op = ir[31:27];
    for (int k = 0; k < 8; k++) exp_seq[k] = '0;
    exp_seq[0] = b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN);
    exp_seq[1] = b(ZLOUT) | b(PCIN) | b(RD) | b(MDRIN);
    exp_seq[2] = b(MDROUT) | b(IRIN);
    exp_len = 3;
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01011: begin
        case (op)
          5'b00011: a = O_ADD;  5'b00100: a = O_SUB;  5'b00101: a = O_AND;
          5'b00110: a = O_OR;   5'b00111: a = O_ROR;  5'b01000: a = O_ROL;
          5'b01001: a = O_SHR;  default:  a = O_SHL;
        endcase
        exp_seq[3] = b(GRB) | b(ROUT) | b(YIN);
        exp_seq[4] = b(GRC) | b(ROUT) | b(a) | b(ZIN);
        exp_seq[5] = b(ZLOUT) | b(GRA) | b(RIN);
        exp_len = 6;
      end
      5'b01100, 5'b01101, 5'b01110: begin
        a = (op == 5'b01100) ? O_ADD : (op == 5'b01101) ? O_AND : O_OR;
        exp_seq[3] = b(GRB) | b(ROUT) | b(YIN);
        exp_seq[4] = b(COUT) | b(a) | b(ZIN);
        exp_seq[5] = b(ZLOUT) | b(GRA) | b(RIN);
        exp_len = 6;
      end
      5'b10001, 5'b10010: begin
        exp_seq[3] = b(GRB) | b(ROUT) | b(op == 5'b10001 ? O_NEG : O_NOT) | b(ZIN);
        exp_seq[4] = b(ZLOUT) | b(GRA) | b(RIN);
        exp_len = 5;
      end
      5'b01111, 5'b10000: if (MD) begin
        exp_seq[3] = b(GRA) | b(ROUT) | b(YIN);
        exp_seq[4] = b(GRB) | b(ROUT) | b(op == 5'b01111 ? O_MUL : O_DIV) | b(ZIN);
        exp_seq[5] = b(ZLOUT) | b(LOIN);
        exp_seq[6] = b(ZHOUT) | b(HIIN);
        exp_len = 8;
      end
      5'b00000, 5'b00001, 5'b00010: begin
        exp_seq[3] = b(GRB) | b(BAOUT) | b(YIN);
        exp_seq[4] = b(COUT) | b(O_ADD) | b(ZIN);
        if (op == 5'b00001) begin
          exp_seq[5] = b(ZLOUT) | b(GRA) | b(RIN);
          exp_len = 6;
        end else begin
          exp_seq[5] = b(ZLOUT) | b(MARIN);
          exp_len = 8;
          if (op == 5'b00000) begin
            exp_seq[6] = b(RD) | b(MDRIN);
            exp_seq[7] = b(MDROUT) | b(GRA) | b(RIN);
          end else begin
            exp_seq[6] = b(GRA) | b(ROUT) | b(MDRIN);
            exp_seq[7] = b(WR);
          end
        end
      end
      5'b10100: begin exp_seq[3] = b(GRA) | b(ROUT) | b(PCIN);    exp_len = 4; end
      5'b10110: begin exp_seq[3] = b(INPOUT) | b(GRA) | b(RIN);   exp_len = 4; end
      5'b10111: begin exp_seq[3] = b(GRA) | b(ROUT) | b(OUTP);    exp_len = 4; end
      5'b11000: begin exp_seq[3] = b(HIOUT) | b(GRA) | b(RIN);    exp_len = 4; end
      5'b11001: begin exp_seq[3] = b(LOOUT) | b(GRA) | b(RIN);    exp_len = 4; end
      default: exp_len = 3;
    endcase
    for (int k = 0; k < 8; k++) if (k < exp_len) exp_seq[k] |= b(RUN);
  endtask

  task automatic check(input string tag, input int k, input logic [39:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step %0d observed=%h expected=%h", tag, k, obs, expv);
    end
    checks++;
    assert ($countones(obs[37:28]) <= 1 && $countones(obs[12:1]) + int'(obs[0]) <= 1) else begin
      errors++;
      $error("FAIL %s_onehot step %0d observed=%h expected=at most one bus/op select", tag, k, obs);
    end
  endtask

  // Entered at a falling edge with the DUT in T0; leaves at the falling edge after the last step.
  task automatic run_instr(input string tag, input logic [31:0] ir, input int stop_after);
    IR = ir;
    build_expected(ir);
    for (int k = 0; k < exp_len && k < stop_after; k++) begin
      check(tag, k, exp_seq[k]);
      @(negedge clk);
    end
  endtask

  logic [31:0] rnd;

  initial begin
    clear = 1'b1;
    IR    = 32'h0;
    @(negedge clk);
    check("reset_hold1", 0, b(DPCLR));
    @(negedge clk);
    check("reset_hold2", 0, b(DPCLR));
    clear = 1'b0;
    @(negedge clk);
    check("t0_after_release", 0, b(RUN) | b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN));

    run_instr("add", 32'h18918000, 99);
    run_instr("ld",  32'h00900010, 99);
    run_instr("mul", 32'h79A00000, 99);
    run_instr("jr",  32'hA2800000, 99);
    run_instr("st",  32'h10900010, 99);
    run_instr("nop", 32'hD0000000, 99);
    run_instr("unimpl", 32'h50000000, 99);

    for (int n = 0; n < 80; n++) begin
      rnd = $urandom();
      if (rnd[31:27] == 5'b11011) rnd[31:27] = 5'b11010;
      run_instr("random", rnd, 99);
    end

    // Clear in the middle of an ld must abandon it immediately.
    run_instr("ld_abort", 32'h00900010, 5);
    clear = 1'b1;
    @(negedge clk);
    check("mid_clear_reset", 0, b(DPCLR));
    clear = 1'b0;
    @(negedge clk);
    check("mid_clear_t0", 0, b(RUN) | b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN));

    run_instr("halt", 32'hD8000000, 99);
    for (int c = 0; c < 20; c++) begin
      check("halt_idle", c, 40'h0);
      @(negedge clk);
    end
    clear = 1'b1;
    @(negedge clk);
    check("halt_clear_reset", 0, b(DPCLR));
    clear = 1'b0;
    @(negedge clk);
    run_instr("add_after_halt", 32'h18918000, 99);
    check("final_t0", 0, b(RUN) | b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
